// File: rtl/mips_pkg.sv
// Shared MIPS-style pipeline definitions: opcodes, EX/MEM and MEM/WB bus layouts,
// MEM-stage handshake states and small decode/pack helpers.
package mips_pkg;

    localparam int XLEN  = 32;
    localparam int OP_W  = 6;
    localparam int REG_W = 5;

    localparam int EXM_W         = 76;
    localparam int EXM_SDATA_LSB = 44;
    localparam int EXM_OP_LSB    = 38;
    localparam int EXM_ALU_LSB   = 6;
    localparam int EXM_DEST_LSB  = 1;
    localparam int EXM_ISR_BIT   = 0;

    localparam int WB_W        = 38;
    localparam int WB_DATA_LSB = 6;
    localparam int WB_DEST_LSB = 1;
    localparam int WB_RW_BIT   = 0;

    localparam logic [OP_W-1:0] OP_ADD  = 6'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 6'd1;
    localparam logic [OP_W-1:0] OP_AND  = 6'd2;
    localparam logic [OP_W-1:0] OP_OR   = 6'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 6'd4;
    localparam logic [OP_W-1:0] OP_SLT  = 6'd5;
    localparam logic [OP_W-1:0] OP_ADDI = 6'd8;
    localparam logic [OP_W-1:0] OP_ANDI = 6'd9;
    localparam logic [OP_W-1:0] OP_ORI  = 6'd10;
    localparam logic [OP_W-1:0] OP_XORI = 6'd11;
    localparam logic [OP_W-1:0] OP_SLLI = 6'd12;
    localparam logic [OP_W-1:0] OP_LW   = 6'd13;
    localparam logic [OP_W-1:0] OP_SW   = 6'd14;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} mem_state_e;
    typedef enum logic [1:0] {CLS_ALU, CLS_LW, CLS_SW, CLS_UNK} op_class_e;

    function automatic op_class_e op_class(input logic [OP_W-1:0] op);
        op_class_e c;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT,
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI: c = CLS_ALU;
            OP_LW:   c = CLS_LW;
            OP_SW:   c = CLS_SW;
            default: c = CLS_UNK;
        endcase
        return c;
    endfunction

    // A write to r0 never asserts reg_write, whatever the instruction class.
    function automatic logic [WB_W-1:0] pack_wb(input logic [XLEN-1:0]  data,
                                                 input logic [REG_W-1:0] dest,
                                                 input logic             rw);
        logic [WB_W-1:0] w;
        w = '0;
        w[WB_DATA_LSB +: XLEN]  = data;
        w[WB_DEST_LSB +: REG_W] = dest;
        w[WB_RW_BIT]            = rw && (dest != '0);
        return w;
    endfunction

endpackage

// File: rtl/mem_req_fsm.sv
// Data-memory request/response handshake for one load or store at a time.
// Request fields are registered and held until the memory accepts them.
import mips_pkg::*;

module mem_req_fsm (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_load,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic            dmem_ready,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            busy,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic            done,
    output logic            done_load,
    output logic [XLEN-1:0] ld_data
);

    mem_state_e      state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        done      = 1'b0;
        done_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    we_d    = !is_load;
                    addr_d  = addr;
                    wdata_d = is_load ? '0 : wdata;
                end
            end
            ST_REQ: begin
                if (dmem_ready) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end else if (dmem_rvalid) begin
                        // Accept and response in the same cycle: skip RESP entirely.
                        done      = 1'b1;
                        done_load = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (dmem_rvalid) begin
                    done      = 1'b1;
                    done_load = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy       = (state_q != ST_IDLE);
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign ld_data    = done_load ? dmem_rdata : '0;

endmodule

// File: rtl/memory_access.sv
// MEM pipeline stage: decodes the EX/MEM bus, runs loads/stores through the
// handshake FSM and registers the MEM/WB bus.
import mips_pkg::*;

module memory_access #(
    parameter logic ALIGN_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [EXM_W-1:0]  ex_mem,
    output logic              mem_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_ready,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              mem_wb_valid,
    output logic [WB_W-1:0]   mem_wb,
    output logic              misalign_err
);

    logic [XLEN-1:0]  ex_sdata, ex_alu;
    logic [OP_W-1:0]  ex_op;
    logic [REG_W-1:0] ex_dest;
    logic             unused_is_r;

    assign ex_sdata    = ex_mem[EXM_SDATA_LSB +: XLEN];
    assign ex_op       = ex_mem[EXM_OP_LSB +: OP_W];
    assign ex_alu      = ex_mem[EXM_ALU_LSB +: XLEN];
    assign ex_dest     = ex_mem[EXM_DEST_LSB +: REG_W];
    assign unused_is_r = ex_mem[EXM_ISR_BIT];

    op_class_e cls;
    logic      accept, is_mem, misalign, start;

    assign cls      = op_class(ex_op);
    assign accept   = ex_valid && !mem_stall;
    assign is_mem   = (cls == CLS_LW) || (cls == CLS_SW);
    assign misalign = ALIGN_CHECK && is_mem && (ex_alu[1:0] != 2'b00);
    assign start    = accept && is_mem && !misalign;

    logic            mem_done, ld_done;
    logic [XLEN-1:0] ld_data;

    mem_req_fsm u_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_load     (cls == CLS_LW),
        .addr        ({ex_alu[XLEN-1:2], 2'b00}),
        .wdata       (ex_sdata),
        .dmem_ready  (dmem_ready),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .busy        (mem_stall),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .done        (mem_done),
        .done_load   (ld_done),
        .ld_data     (ld_data)
    );

    logic [REG_W-1:0] dest_q, dest_d;
    logic [WB_W-1:0]  mem_wb_q, mem_wb_d;
    logic             wb_valid_q, wb_valid_d;
    logic             mis_q, mis_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dest_q     <= '0;
            mem_wb_q   <= '0;
            wb_valid_q <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            dest_q     <= dest_d;
            mem_wb_q   <= mem_wb_d;
            wb_valid_q <= wb_valid_d;
            mis_q      <= mis_d;
        end
    end

    // Non-writing retirements (store, unknown, dropped access) carry zero data.
    always_comb begin
        dest_d     = dest_q;
        mem_wb_d   = mem_wb_q;
        wb_valid_d = 1'b0;
        mis_d      = 1'b0;
        if (start) begin
            dest_d = ex_dest;
        end
        if (accept && !start) begin
            wb_valid_d = 1'b1;
            mis_d      = misalign;
            mem_wb_d   = pack_wb((cls == CLS_ALU) ? ex_alu : '0, ex_dest, cls == CLS_ALU);
        end else if (mem_done) begin
            wb_valid_d = 1'b1;
            mem_wb_d   = pack_wb(ld_data, dest_q, ld_done);
        end
    end

    assign mem_wb       = mem_wb_q;
    assign mem_wb_valid = wb_valid_q;
    assign misalign_err = mis_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: a spec-level retirement model feeds a
// scoreboard checked every cycle, plus literal expectations per scenario.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [75:0] ex_mem;
    logic        mem_stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ready, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        mem_wb_valid;
    logic [37:0] mem_wb;
    logic        misalign_err;

    memory_access #(.ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_mem(ex_mem),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_wb_valid(mem_wb_valid), .mem_wb(mem_wb), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [4:0]  dest;
        logic        rw;
        logic        mis;
        int          edge_n;
    } exp_t;

    exp_t exp_q[$];

    // Spec rules: which instructions write back, what value, and whether dropped.
    function automatic exp_t model(input logic [5:0] op, input logic [31:0] alu,
                                   input logic [4:0] dest, input logic [31:0] rd);
        exp_t e;
        logic is_alu, is_mem;
        is_alu = (op <= 6'd5) || (op >= 6'd8 && op <= 6'd12);
        is_mem = (op == 6'd13) || (op == 6'd14);
        e.dest = dest; e.mis = 1'b0; e.data = 32'h0; e.rw = 1'b0; e.edge_n = 0;
        if (is_mem && alu[1:0] != 2'b00) begin
            e.mis = 1'b1;
        end else if (is_alu) begin
            e.data = alu; e.rw = (dest != 0);
        end else if (op == 6'd13) begin
            e.data = rd;  e.rw = (dest != 0);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wb_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_retire", mem_wb_valid, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_mem_wb", mem_wb, {e.data, e.dest, e.rw});
                    chk("sb_misalign", misalign_err, e.mis);
                    chk("sb_latency", cyc, e.edge_n);
                end
            end else begin
                chk("misalign_idle", misalign_err, 1'b0);
                if (exp_q.size() > 0 && cyc > exp_q[0].edge_n) begin
                    chk("missing_retire", mem_wb_valid, 1'b1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Called at #1 after a clock edge; returns #1 after the retire edge.
    task automatic run_op(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] sd,
                          input logic [4:0] dest, input int rdy_w, input int rv_w,
                          input logic [31:0] rd, output int req_cyc);
        exp_t e;
        logic issued, is_ld;
        int   lat;
        issued  = (op == 6'd13 || op == 6'd14) && (alu[1:0] == 2'b00);
        is_ld   = (op == 6'd13);
        lat     = !issued ? 1 : (is_ld ? 2 + rdy_w + rv_w : 2 + rdy_w);
        e       = model(op, alu, dest, rd);
        e.edge_n = cyc + lat;
        exp_q.push_back(e);
        req_cyc = 0;
        ex_valid = 1'b1;
        ex_mem   = {sd, op, alu, dest, 1'b0};
        @(posedge clk); #1;
        ex_valid = 1'b0;
        if (!issued) begin
            chk("nomem_req", dmem_req, 1'b0);
            chk("nomem_stall", mem_stall, 1'b0);
            return;
        end
        for (int i = 0; i <= rdy_w; i++) begin
            chk("req_hi", dmem_req, 1'b1);
            chk("req_stall", mem_stall, 1'b1);
            chk("req_we", dmem_we, !is_ld);
            chk("req_addr", dmem_addr, alu);
            if (!is_ld) chk("req_wdata", dmem_wdata, sd);
            req_cyc++;
            if (i == rdy_w) begin
                dmem_ready = 1'b1;
                if (is_ld && rv_w == 0) begin dmem_rvalid = 1'b1; dmem_rdata = rd; end
            end
            @(posedge clk); #1;
            dmem_ready = 1'b0; dmem_rvalid = 1'b0;
        end
        if (is_ld && rv_w > 0) begin
            for (int i = 0; i < rv_w; i++) begin
                chk("resp_req_lo", dmem_req, 1'b0);
                chk("resp_stall", mem_stall, 1'b1);
                if (i == rv_w - 1) begin dmem_rvalid = 1'b1; dmem_rdata = rd; end
                @(posedge clk); #1;
                dmem_rvalid = 1'b0;
            end
        end
        chk("post_stall", mem_stall, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rc;
        rst_n = 1'b0; ex_valid = 1'b0; ex_mem = '0;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk); #1;
        chk("rst_stall", mem_stall, 1'b0);
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_we", dmem_we, 1'b0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_wb", mem_wb, 38'h0);
        chk("rst_wbv", mem_wb_valid, 1'b0);
        chk("rst_mis", misalign_err, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(6'd0, 32'h0000_0005, 32'h0, 5'd3, 0, 0, 32'h0, rc);
        chk("alu_lit", mem_wb, {32'h0000_0005, 5'd3, 1'b1});
        chk("alu_vld", mem_wb_valid, 1'b1);
        run_op(6'd1,  32'hA5A5_0001, 32'h0, 5'd4,  0, 0, 32'h0, rc);
        run_op(6'd12, 32'h8000_0000, 32'h0, 5'd31, 0, 0, 32'h0, rc);
        run_op(6'd8,  32'h0000_00FF, 32'h0, 5'd1,  0, 0, 32'h0, rc);
        chk("b2b_lit", mem_wb, {32'h0000_00FF, 5'd1, 1'b1});
        run_op(6'd2, 32'hFFFF_FFFF, 32'h0, 5'd0, 0, 0, 32'h0, rc);
        chk("dest0_lit", mem_wb, {32'hFFFF_FFFF, 5'd0, 1'b0});
        run_op(6'd7, 32'h0000_1234, 32'h0, 5'd9, 0, 0, 32'h0, rc);
        chk("unk_lit", mem_wb, {32'h0, 5'd9, 1'b0});

        run_op(6'd14, 32'h0000_0100, 32'hDEAD_BEEF, 5'd2, 2, 0, 32'h0, rc);
        chk("sw_req_cycles", rc, 3);
        chk("sw_lit", mem_wb, {32'h0, 5'd2, 1'b0});
        run_op(6'd13, 32'h0000_0200, 32'h0, 5'd7, 0, 3, 32'h1234_5678, rc);
        chk("lw_lit", mem_wb, {32'h1234_5678, 5'd7, 1'b1});
        run_op(6'd13, 32'h0000_0208, 32'h0, 5'd6, 0, 0, 32'h0BAD_F00D, rc);
        chk("lw_fast_req", rc, 1);
        chk("lw_fast_lit", mem_wb, {32'h0BAD_F00D, 5'd6, 1'b1});
        run_op(6'd13, 32'h0000_0204, 32'h0, 5'd5, 1, 2, 32'hCAFE_F00D, rc);
        run_op(6'd0, 32'h0000_0042, 32'h0, 5'd10, 0, 0, 32'h0, rc);

        run_op(6'd13, 32'h0000_0102, 32'h0, 5'd7, 0, 0, 32'h0, rc);
        chk("mis_pulse", misalign_err, 1'b1);
        chk("mis_lit", mem_wb, {32'h0, 5'd7, 1'b0});
        run_op(6'd14, 32'h0000_0103, 32'h1111_2222, 5'd0, 0, 0, 32'h0, rc);
        @(posedge clk); #1;
        chk("mis_one_pulse", misalign_err, 1'b0);

        // Reset while waiting for a load response.
        ex_valid = 1'b1;
        ex_mem   = {32'h0, 6'd13, 32'h0000_0300, 5'd8, 1'b0};
        @(posedge clk); #1;
        ex_valid = 1'b0; dmem_ready = 1'b1;
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        chk("resp_stall_hi", mem_stall, 1'b1);
        chk("resp_req_lo", dmem_req, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        chk("rrst_stall", mem_stall, 1'b0);
        chk("rrst_req", dmem_req, 1'b0);
        chk("rrst_we", dmem_we, 1'b0);
        chk("rrst_addr", dmem_addr, 32'h0);
        chk("rrst_wb", mem_wb, 38'h0);
        chk("rrst_wbv", mem_wb_valid, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
        repeat (2) @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        chk("stray_rv_wbv", mem_wb_valid, 1'b0);
        chk("stray_rv_stall", mem_stall, 1'b0);
        run_op(6'd3, 32'h0000_0077, 32'h0, 5'd12, 0, 0, 32'h0, rc);
        chk("post_rst_alu", mem_wb, {32'h0000_0077, 5'd12, 1'b1});

        repeat (3) @(posedge clk); #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_access.md
# memory_access

Pipeline MEM stage that consumes the packed EX/MEM bus and produces the MEM/WB bus.
- ALU operations pass their result through in one cycle.
- Loads and stores run a request/response handshake with the data memory and stall the pipeline until the access completes.
- Sits between the execution stage's EX/MEM register and the write-back stage.

## Interface
Parameters:
- ALIGN_CHECK, 1, when 1 a word access with addr[1:0]≠0 is not issued and is flagged as misaligned.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  the ex_mem bus holds a valid instruction this cycle.
- ex_mem  in  76  bit fields:
  - [75:44] store data
  - [43:38] opcode
  - [37:6] ALU result / address
  - [5:1] dest_reg
  - [0] is_r
- mem_stall  out  1  upstream must hold ex_mem/ex_valid stable.
- dmem_req  out  1  memory request valid.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  32  byte address; word aligned.
- dmem_wdata  out  32  store data.
- dmem_ready  in  1  memory accepts the request this cycle.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  32  load data.
- mem_wb_valid  out  1  mem_wb holds a retiring instruction, one-cycle pulse per instruction.
- mem_wb  out  38  bit fields:
  - [37:6] write-back data
  - [5:1] dest_reg
  - [0] reg_write
- misalign_err  out  1  one-cycle pulse when a misaligned access is dropped.

## Operation
- Opcode classes:
  - ALU: 0–5 and 8–12.
  - LW = 13.
  - SW = 14.
  - Anything else is unknown: it retires with wb data 0 and reg_write 0.
- reg_write is 1 for ALU and LW, 0 for SW and unknown. It is forced to 0 when dest_reg = 0.
- FSM states:
  - IDLE: on ex_valid, capture ex_mem.
    - ALU or unknown → retire immediately; stay in IDLE.
    - LW or SW → go to REQ.
    - Misaligned with ALIGN_CHECK=1 → pulse misalign_err, retire with reg_write 0, stay in IDLE.
  - REQ: dmem_req=1, with addr, we and wdata driven from the captured registers.
    - On dmem_ready: a SW retires and returns to IDLE.
    - On dmem_ready for a LW: if dmem_rvalid is in the same cycle, retire with dmem_rdata; otherwise go to RESP.
  - RESP: wait for dmem_rvalid, then retire with dmem_rdata and go to IDLE.
- mem_stall = (state ≠ IDLE). ex_valid is ignored while mem_stall=1.
- No buffering: at most one instruction is in flight.
- dmem_rvalid outside RESP, or outside REQ with ready, is ignored.

## Timing
- Reset, asynchronous: state=IDLE. All outputs are 0, including mem_wb, mem_wb_valid, dmem_* and misalign_err.
- Reset mid-access: the request is dropped immediately and nothing retires. Any late dmem_rvalid after reset is ignored.
- ALU op:
  - ex_valid sampled at edge N.
  - mem_wb and mem_wb_valid are updated at edge N, visible through cycle N+1.
  - Latency is 1 cycle.
- SW:
  - Captured at edge N.
  - dmem_req is high from cycle N+1.
  - The retire edge is the one where dmem_ready=1, so a minimum latency of 2.
- LW:
  - Minimum latency is 2 when ready and rvalid coincide.
  - Otherwise the latency is 2 + (request wait) + (response wait) cycles.
- dmem_req, dmem_addr, dmem_we and dmem_wdata are registered. They are stable while dmem_req=1 and ready=0.
- mem_stall is combinational from state. It rises in the cycle after a memory op is captured and falls in the cycle after retirement.
- Back-to-back ALU ops retire every cycle. A new op is accepted in the cycle after a memory op retires.

## Structure
- Shared package mips_pkg holds:
  - opcode constants (OP_ADD…OP_SLLI, OP_LW=13, OP_SW=14)
  - EX/MEM and MEM/WB field offsets and widths
  - the state enum
- One sub-module, mem_req_fsm, holds the IDLE/REQ/RESP handshake and produces dmem_req, done and load-data capture.
- The top level does decode, reg_write generation and the MEM/WB register.

## Test plan
- ALU pass-through: opcode 0, alu 0x0000_0005, dest 3, ex_valid one cycle → next cycle mem_wb = {0x5, 3, 1}, mem_wb_valid=1, mem_stall=0.
- SW with ready delayed 2 cycles: addr 0x100, data 0xDEAD_BEEF → dmem_req/we=1 held stable 3 cycles, addr/wdata correct; retire with reg_write=0; mem_stall high 3 cycles.
- LW, ready immediate, rvalid 3 cycles later: rdata 0x1234_5678, dest 7 → mem_wb = {0x1234_5678, 7, 1} on the rvalid edge; only one mem_wb_valid pulse.
- LW with ready and rvalid in the same cycle → retire in that cycle, with no RESP cycle.
- Misaligned LW at 0x102 with ALIGN_CHECK=1 → no dmem_req, misalign_err pulse, mem_wb reg_write=0. Write to dest 0 on an ALU op → reg_write=0.
- Assert rst_n low while in RESP, then release → all outputs 0, state IDLE, and a stray rvalid afterwards produces no retirement.
